// File: rtl/phv_merger.sv
`default_nettype none
// ============================================================================
//  Module   : phv_merger
//  Purpose  : Merges ALU results into the original PHV containers under a
//             per-container update mask, appends the untouched remainder
//             bits and queues the merged PHV in a small output FIFO with a
//             registered valid/ready hand-off to the downstream stage.
//  Ports    : clk, rst_n        - clock, asynchronous active-low reset
//             alu_out_valid     - incoming beat valid
//             alu_out_4B        - ALU results, container i at [32*i +: 32]
//             phv_orig_4B       - original containers, same layout
//             phv_remain_in     - remainder/metadata bits, passed through
//             upd_mask          - bit i selects ALU result for container i
//             ready_out         - registered: a beat can be accepted
//             phv_out           - registered head-of-queue merged PHV
//             phv_out_valid     - registered: phv_out holds a PHV
//             ready_in          - downstream accepts phv_out
//             phv_count         - PHVs delivered downstream (wrapping)
//             overflow_err      - sticky: a beat was dropped while full
//  Revision : 1.0 - initial release
// ============================================================================
module phv_merger #(
    parameter int PHV_LEN  = 2304,
    parameter int WIDTH_4B = 32,
    parameter int NUM_CONT = 64,
    parameter int DEPTH    = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   alu_out_valid,
    input  logic [WIDTH_4B*NUM_CONT-1:0]           alu_out_4B,
    input  logic [WIDTH_4B*NUM_CONT-1:0]           phv_orig_4B,
    input  logic [PHV_LEN-WIDTH_4B*NUM_CONT-1:0]   phv_remain_in,
    input  logic [NUM_CONT-1:0]                    upd_mask,
    output logic                                   ready_out,
    output logic [PHV_LEN-1:0]                     phv_out,
    output logic                                   phv_out_valid,
    input  logic                                   ready_in,
    output logic [31:0]                            phv_count,
    output logic                                   overflow_err
);

    localparam int c_rem_w = PHV_LEN - WIDTH_4B*NUM_CONT;
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_VALID = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [PHV_LEN-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_occ;
    logic [c_cnt_w-1:0]   w_occ_next;
    logic [PHV_LEN-1:0]   w_merged;
    logic [PHV_LEN-1:0]   w_head_next;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_last) ? '0 : p + c_ptr_w'(1);
    endfunction

    // Container merge and packing: remainder occupies the low bits.
    assign w_merged[c_rem_w-1:0] = phv_remain_in;
    for (genvar gi = 0; gi < NUM_CONT; gi++) begin : g_merge
        assign w_merged[c_rem_w + WIDTH_4B*gi +: WIDTH_4B] =
            upd_mask[gi] ? alu_out_4B [WIDTH_4B*gi +: WIDTH_4B]
                         : phv_orig_4B[WIDTH_4B*gi +: WIDTH_4B];
    end

    assign w_full = (r_occ == c_depth);
    assign w_pop  = phv_out_valid & ready_in;
    // A pop frees a slot in the same cycle, so a full queue still takes a beat.
    assign w_push = alu_out_valid & (~w_full | w_pop);
    assign w_drop = alu_out_valid & w_full & ~w_pop;

    always_comb begin
        w_occ_next = r_occ;
        if (w_push && !w_pop) begin
            w_occ_next = r_occ + c_cnt_w'(1);
        end else if (w_pop && !w_push) begin
            w_occ_next = r_occ - c_cnt_w'(1);
        end
    end

    // Value the registered head takes after this cycle's push/pop. When the
    // queue holds a single entry and is popped and pushed together, the new
    // beat lands in the slot right behind the head, so it is taken directly.
    always_comb begin
        w_head_next = phv_out;
        if (w_pop) begin
            if (r_occ > c_cnt_w'(1)) begin
                w_head_next = r_mem[ptr_inc(r_rd_ptr)];
            end else if (w_push) begin
                w_head_next = w_merged;
            end
        end else if (r_occ == '0 && w_push) begin
            w_head_next = w_merged;
        end
    end

    // Output-hold state machine: next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_state_next = (w_occ_next == c_depth) ? ST_FULL : ST_VALID;
                end
            end
            ST_VALID: begin
                if (w_push && !w_pop && w_occ_next == c_depth) begin
                    w_state_next = ST_FULL;
                end else if (w_pop && !w_push && w_occ_next == '0) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_pop && !w_push) begin
                    w_state_next = (w_occ_next == '0) ? ST_EMPTY : ST_VALID;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_EMPTY;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_occ         <= '0;
            phv_out       <= '0;
            phv_out_valid <= 1'b0;
            ready_out     <= 1'b1;
            phv_count     <= '0;
            overflow_err  <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_occ         <= w_occ_next;
            phv_out       <= w_head_next;
            phv_out_valid <= (w_state_next != ST_EMPTY);
            ready_out     <= (w_occ_next < c_depth);
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr  <= ptr_inc(r_rd_ptr);
                phv_count <= phv_count + 32'd1;
            end
            if (w_drop) begin
                overflow_err <= 1'b1;
            end
        end
    end

    // Queue storage carries data only; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_merged;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_phv_merger.sv
`default_nettype none
// ============================================================================
//  Module   : tb_phv_merger
//  Purpose  : Directed self-checking bench for phv_merger.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_phv_merger;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alu_out_valid;
    logic [2047:0]   alu_out_4B;
    logic [2047:0]   phv_orig_4B;
    logic [255:0]    phv_remain_in;
    logic [63:0]     upd_mask;
    logic            ready_out;
    logic [2303:0]   phv_out;
    logic            phv_out_valid;
    logic            ready_in;
    logic [31:0]     phv_count;
    logic            overflow_err;

    int n_checks = 0;
    int n_errors = 0;

    phv_merger dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_out_valid (alu_out_valid),
        .alu_out_4B    (alu_out_4B),
        .phv_orig_4B   (phv_orig_4B),
        .phv_remain_in (phv_remain_in),
        .upd_mask      (upd_mask),
        .ready_out     (ready_out),
        .phv_out       (phv_out),
        .phv_out_valid (phv_out_valid),
        .ready_in      (ready_in),
        .phv_count     (phv_count),
        .overflow_err  (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2303:0] got, input logic [2303:0] exp);
        int w;
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            w = 0;
            for (int k = 35; k >= 0; k--) begin
                if (got[64*k +: 64] !== exp[64*k +: 64]) w = k;
            end
            $display("FAIL %s: got %h expected %h (64-bit word %0d)",
                     tag, got[64*w +: 64], exp[64*w +: 64], w);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2047:0] pat(input logic [3:0] kind, input int seed);
        logic [2047:0] v;
        for (int i = 0; i < 64; i++) v[32*i +: 32] = {kind, 12'(seed), 16'(i)};
        return v;
    endfunction

    function automatic logic [255:0] rem(input int seed);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = {4'hC, 12'(seed), 16'hBEEF};
        return v;
    endfunction

    function automatic logic [63:0] mask_of(input int seed);
        return {32'(seed) * 32'h9E37_79B9, 32'h0F0F_0F0F ^ 32'(seed)};
    endfunction

    // Reference merge built container by container.
    function automatic logic [2303:0] exp_phv(input int seed);
        logic [2303:0] v;
        logic [2047:0] a;
        logic [2047:0] o;
        logic [63:0]   m;
        a = pat(4'hA, seed);
        o = pat(4'h5, seed);
        m = mask_of(seed);
        v[255:0] = rem(seed);
        for (int i = 0; i < 64; i++)
            v[256 + 32*i +: 32] = m[i] ? a[32*i +: 32] : o[32*i +: 32];
        return v;
    endfunction

    task automatic drive_beat(input int seed, input logic [63:0] m);
        alu_out_4B    = pat(4'hA, seed);
        phv_orig_4B   = pat(4'h5, seed);
        phv_remain_in = rem(seed);
        upd_mask      = m;
        alu_out_valid = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        alu_out_valid = 1'b0;
        alu_out_4B    = '0;
        phv_orig_4B   = '0;
        phv_remain_in = '0;
        upd_mask      = '0;
        ready_in      = 1'b0;

        // Reset state
        #12;
        chk("rst_valid", phv_out_valid, 1'b0);
        chk("rst_ready", ready_out, 1'b1);
        chk("rst_count", phv_count, 32'd0);
        chk("rst_ovf",   overflow_err, 1'b0);
        chk("rst_phv",   phv_out, '0);
        rst_n = 1'b1;

        // Single beat, container 0 updated, one-cycle latency
        alu_out_4B[31:0]   = 32'hDEAD_BEEF;
        phv_orig_4B[31:0]  = 32'h1111_1111;
        phv_orig_4B[63:32] = 32'h2222_2222;
        phv_remain_in      = 256'hAB;
        upd_mask           = 64'h1;
        alu_out_valid      = 1'b1;
        step();
        alu_out_valid = 1'b0;
        chk("single_c0",     phv_out[287:256], 32'hDEAD_BEEF);
        chk("single_c1",     phv_out[319:288], 32'h2222_2222);
        chk("single_remain", phv_out[255:0], 256'hAB);
        chk("single_valid",  phv_out_valid, 1'b1);
        ready_in = 1'b1;
        step();
        chk("single_drain", phv_out_valid, 1'b0);
        chk("single_count", phv_count, 32'd1);

        // Mask extremes: all-original, then all-ALU (push+pop at occupancy 1)
        drive_beat(1, 64'h0);
        step();
        chk("mask0_phv", phv_out, {pat(4'h5, 1), rem(1)});
        chk("mask0_valid", phv_out_valid, 1'b1);
        drive_beat(2, '1);
        step();
        chk("mask1_phv", phv_out, {pat(4'hA, 2), rem(2)});
        alu_out_valid = 1'b0;
        step();
        chk("mask_drain", phv_out_valid, 1'b0);
        chk("mask_count", phv_count, 32'd3);

        // Full buffer with continuous flow: one PHV per cycle, in order
        ready_in = 1'b0;
        drive_beat(10, mask_of(10));
        step();
        drive_beat(11, mask_of(11));
        step();
        chk("flow_full_ready", ready_out, 1'b0);
        chk("flow_head", phv_out, exp_phv(10));
        ready_in = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive_beat(12 + k, mask_of(12 + k));
            step();
            chk($sformatf("flow_phv%0d", k), phv_out, exp_phv(11 + k));
            chk($sformatf("flow_valid%0d", k), phv_out_valid, 1'b1);
        end
        alu_out_valid = 1'b0;
        step();
        chk("flow_tail", phv_out, exp_phv(17));
        step();
        chk("flow_empty", phv_out_valid, 1'b0);
        chk("flow_ovf", overflow_err, 1'b0);
        chk("flow_count", phv_count, 32'd11);

        // Back-pressure: A,B buffered, C dropped, sticky overflow
        ready_in = 1'b0;
        drive_beat(20, mask_of(20));
        step();
        chk("bp_ready_a", ready_out, 1'b1);
        drive_beat(21, mask_of(21));
        step();
        chk("bp_ready_b", ready_out, 1'b0);
        drive_beat(22, mask_of(22));
        step();
        alu_out_valid = 1'b0;
        chk("bp_ovf", overflow_err, 1'b1);
        chk("bp_head_a", phv_out, exp_phv(20));
        step();
        chk("bp_hold_a", phv_out, exp_phv(20));
        chk("bp_hold_valid", phv_out_valid, 1'b1);
        ready_in = 1'b1;
        step();
        chk("bp_head_b", phv_out, exp_phv(21));
        chk("bp_count_a", phv_count, 32'd12);
        step();
        chk("bp_empty", phv_out_valid, 1'b0);
        chk("bp_count_b", phv_count, 32'd13);
        chk("bp_ready_back", ready_out, 1'b1);
        chk("bp_ovf_sticky", overflow_err, 1'b1);

        // Reset mid-operation with two entries held
        ready_in = 1'b0;
        drive_beat(30, mask_of(30));
        step();
        drive_beat(31, mask_of(31));
        step();
        alu_out_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", phv_out_valid, 1'b0);
        chk("mrst_ready", ready_out, 1'b1);
        chk("mrst_count", phv_count, 32'd0);
        chk("mrst_ovf",   overflow_err, 1'b0);
        chk("mrst_phv",   phv_out, '0);
        #2;
        rst_n = 1'b1;
        step();
        chk("mrst_after", phv_out_valid, 1'b0);

        // Delivered-count wrap
        drive_beat(40, mask_of(40));
        step();
        drive_beat(41, mask_of(41));
        step();
        alu_out_valid = 1'b0;
        force dut.phv_count = 32'hFFFF_FFFE;
        #1;
        release dut.phv_count;
        ready_in = 1'b1;
        step();
        chk("wrap_max", phv_count, 32'hFFFF_FFFF);
        chk("wrap_head", phv_out, exp_phv(41));
        step();
        chk("wrap_zero", phv_count, 32'h0000_0000);
        chk("wrap_empty", phv_out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
